axis_bram_adapter_v1_0_reader: RTL and testbench

//   BRAM-to-stream read engine: the read-direction counterpart of the adapter

---
 rtl/axis_bram_adapter_v1_0_reader.sv | 144 ++++++++++++++
 tb/tb_axis_bram_adapter_v1_0_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_adapter_v1_0_reader.sv
// BRAM-to-AXI-Stream read engine: streams the inclusive address range [index_cntl .. size_cntl]
// and absorbs the one-cycle BRAM read latency and downstream backpressure in a 2-entry FIFO.
module axis_bram_adapter_v1_0_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] index_cntl,
  input  logic [ADDR_W-1:0] size_cntl,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic              bram_wen,
  output logic [ADDR_W-1:0] bram_index,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   remaining_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;

  logic [DATA_W-1:0] fifo_data_reg [2];
  logic              fifo_last_reg [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        fifo_count_reg;

  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              last_issue;
  logic [1:0]        credit;
  logic [ADDR_W:0]   word_count;

  assign fifo_empty = (fifo_count_reg == 2'd0);
  assign push       = inflight_reg;
  assign pop        = !fifo_empty && m_axis_tready;
  assign accept     = (state_reg == S_IDLE) && start;
  assign last_issue = (remaining_reg == REM_ONE);
  assign word_count = {1'b0, size_cntl - index_cntl} + REM_ONE;

  // Words in flight plus words buffered after this cycle's pop; a new read
  // is only issued while that total leaves a free FIFO slot for it.
  assign credit = {1'b0, inflight_reg} + fifo_count_reg - {1'b0, pop};
  assign issue  = (state_reg == S_RUN) && (remaining_reg != '0) && (credit < 2'd2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        if (issue && last_issue) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty && !inflight_reg) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg != S_IDLE);
    done    = (state_reg == S_DRAIN) && fifo_empty && !inflight_reg;
    bram_en = issue;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_reg          <= '0;
      remaining_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg      <= index_cntl;
        remaining_reg <= word_count;
      end else if (issue) begin
        addr_reg      <= addr_reg + ADDR_W'(1);
        remaining_reg <= remaining_reg - REM_ONE;
      end
      inflight_reg      <= issue;
      inflight_last_reg <= issue && last_issue;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_last_reg[i] <= 1'b0;
      end
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      fifo_count_reg <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= bram_dout;
        fifo_last_reg[wr_ptr_reg] <= inflight_last_reg;
        wr_ptr_reg                <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      fifo_count_reg <= fifo_count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Data and last are zeroed while the FIFO is empty so stale entries never leak out.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_data_reg[rd_ptr_reg];
  assign m_axis_tlast  = !fifo_empty && fifo_last_reg[rd_ptr_reg];
  assign bram_index    = addr_reg;
  assign bram_wen      = 1'b0;

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_reader.sv
// Scoreboard bench for the BRAM-to-stream reader: a BRAM model answers reads,
// transfers push expected beats into a queue and a negedge monitor pops and compares them.
module tb_axis_bram_adapter_v1_0_reader;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int LIMIT = 200;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] index_cntl = '0;
  logic [AW-1:0] size_cntl = '0;
  logic          busy, done, bram_en, bram_wen;
  logic [AW-1:0] bram_index;
  logic [DW-1:0] bram_dout;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  logic [DW-1:0] mem [512];
  exp_t          exp_q [$];

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int popped = 0;
  int max_out = 0;
  int rmode = 0;
  int stall_left = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  axis_bram_adapter_v1_0_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .index_cntl(index_cntl), .size_cntl(size_cntl),
    .busy(busy), .done(done),
    .bram_en(bram_en), .bram_wen(bram_wen), .bram_index(bram_index), .bram_dout(bram_dout),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | i;
  end

  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_index];

  // tready pattern: 0 = always ready, 1 = toggle, 2 = hold low for 20 cycles of valid data
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: m_axis_tready = ~m_axis_tready;
      2: begin
        if (stall_left > 0) begin
          m_axis_tready = 1'b0;
          if (m_axis_tvalid) stall_left = stall_left - 1;
        end else begin
          m_axis_tready = 1'b1;
        end
      end
      default: m_axis_tready = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    int   outstanding;
    logic pop;
    exp_t e;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(m_axis_tvalid && m_axis_tdata === prev_data && m_axis_tlast === prev_last)) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b data=%0h last=%0b expected valid=1 data=%0h last=%0b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      pop = m_axis_tvalid && m_axis_tready;
      outstanding = issued - popped + int'(bram_en) - int'(pop);
      if (outstanding > max_out) max_out = outstanding;
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%0h last=%0b expected no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
            errors++;
            $display("FAIL beat: got data=%0h last=%0b expected data=%0h last=%0b",
                     m_axis_tdata, m_axis_tlast, e.data, e.last);
          end else begin
            $display("beat ok: data=%0h last=%0b", m_axis_tdata, m_axis_tlast);
          end
        end
        popped++;
      end
      if (bram_en) issued++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic push_expected(input logic [AW-1:0] idx, input int n);
    logic [AW-1:0] a;
    exp_t e;
    a = idx;
    for (int k = 0; k < n; k++) begin
      e.data = mem[a];
      e.last = (k == n - 1);
      exp_q.push_back(e);
      a = a + AW'(1);
    end
  endtask

  task automatic run(input logic [AW-1:0] idx, input logic [AW-1:0] sz, input int mode,
                     input int n_exp, input bit spurious, output int busy_cyc);
    int cyc;
    int done_cyc;
    int first_v;
    push_expected(idx, n_exp);
    rmode = mode;
    stall_left = 20;
    issued = 0;
    popped = 0;
    max_out = 0;
    first_v = 0;
    done_cyc = 0;
    busy_cyc = 0;
    @(posedge clk); #1;
    index_cntl = idx;
    size_cntl = sz;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    index_cntl = idx + AW'(9);
    size_cntl = sz + AW'(3);
    cyc = 1;
    while (cyc <= LIMIT) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (m_axis_tvalid && first_v == 0) first_v = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      start = spurious && (cyc == 2);
      if (start) begin
        index_cntl = AW'(100);
        size_cntl = AW'(200);
      end
    end
    start = 1'b0;
    check("done_seen", 64'(done_cyc != 0), 64'd1);
    if (mode == 0) check("done_cycle", 64'(done_cyc), 64'(n_exp + 3));
    check("first_valid_cycle", 64'(first_v), 64'd3);
    check("beat_count", 64'(popped), 64'(n_exp));
    check("outstanding_le_2", 64'(max_out <= 2), 64'd1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("idle_after_done", {62'd0, busy, done}, 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int bc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {17'd0, busy, done, bram_en, bram_wen, m_axis_tvalid, m_axis_tlast,
                            bram_index, m_axis_tdata}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {17'd0, busy, done, bram_en, bram_wen, m_axis_tvalid, m_axis_tlast,
                              bram_index, m_axis_tdata}, 64'd0);

    run(AW'(0), AW'(15), 0, 16, 1'b0, bc);   // full-rate 16 words
    run(AW'(6), AW'(15), 1, 10, 1'b0, bc);   // toggling ready
    run(AW'(510), AW'(1), 0, 4, 1'b0, bc);   // wrap through 511 -> 0
    run(AW'(7), AW'(7), 0, 1, 1'b0, bc);     // single word
    check("single_busy_cycles", 64'(bc), 64'd4);
    run(AW'(20), AW'(29), 2, 10, 1'b0, bc);  // 20-cycle stall after first valid

    // Reset in the middle of a 16-word transfer
    push_expected(AW'(0), 16);
    rmode = 0;
    issued = 0;
    popped = 0;
    @(posedge clk); #1;
    index_cntl = AW'(0);
    size_cntl = AW'(15);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < LIMIT && popped < 5; c++) @(negedge clk);
    check("midreset_reached_word5", 64'(popped >= 5), 64'd1);
    #1 rstn = 1'b0;
    #1;
    check("midreset_outputs", {17'd0, busy, done, bram_en, bram_wen, m_axis_tvalid, m_axis_tlast,
                               bram_index, m_axis_tdata}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    run(AW'(3), AW'(4), 0, 2, 1'b1, bc);     // new transfer with an ignored start while busy

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
